// File: rtl/rtc_pkg.sv
// Shared field widths, range limits and the 24h-to-12h display helper
// for the hours/minutes/seconds real-time clock.
package rtc_pkg;

    localparam int HOUR_W = 5;
    localparam int MS_W   = 6;

    localparam logic [MS_W-1:0]   SEC_MAX    = 6'd59;
    localparam logic [MS_W-1:0]   MIN_MAX    = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR24_MAX = 5'd23;

    // Returns {am_pm, hour12}; hour24 values 0 and 12 both display as 12.
    function automatic logic [HOUR_W:0] to_12h(input logic [HOUR_W-1:0] hour24);
        logic              pm;
        logic [HOUR_W-1:0] hour12;
        pm     = (hour24 >= HOUR_W'(12));
        hour12 = pm ? (hour24 - HOUR_W'(12)) : hour24;
        if (hour12 == '0) begin
            hour12 = HOUR_W'(12);
        end
        return {pm, hour12};
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the fabric clock down to a one-second advance strobe.
// adv is combinational and marks the edge at which the count wraps.
module rtc_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic adv
);

    localparam int CNT_W = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign adv = run && (cnt == CNT_LAST);

    // clr restarts the second so a freshly loaded time lasts a full period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rtc_clock_hms.sv
// Hours/minutes/seconds real-time clock with internal prescaler,
// 12h/24h display, range-checked time load and a one-shot alarm.
module rtc_clock_hms
    import rtc_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int RST_HOUR24 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              mode_24h,
    input  logic              load,
    input  logic [HOUR_W-1:0] load_hour24,
    input  logic [MS_W-1:0]   load_min,
    input  logic [MS_W-1:0]   load_sec,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] alarm_hour24,
    input  logic [MS_W-1:0]   alarm_min,
    output logic [HOUR_W-1:0] hours,
    output logic [MS_W-1:0]   minutes,
    output logic [MS_W-1:0]   seconds,
    output logic              am_pm,
    output logic              tick,
    output logic              load_err,
    output logic              alarm_hit
);

    logic [HOUR_W-1:0] hour24_q;
    logic [MS_W-1:0]   min_q;
    logic [MS_W-1:0]   sec_q;
    logic              tick_q;
    logic              load_err_q;
    logic              alarm_hit_q;

    logic              adv;
    logic              load_ok;
    logic [HOUR_W-1:0] hour24_n;
    logic [MS_W-1:0]   min_n;
    logic [MS_W-1:0]   sec_n;
    logic              alarm_match;
    logic [HOUR_W:0]   disp12;

    assign load_ok = load
                  && (load_hour24 <= HOUR24_MAX)
                  && (load_min    <= MIN_MAX)
                  && (load_sec    <= SEC_MAX);

    rtc_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .clr   (load_ok),
        .adv   (adv)
    );

    // Time one second ahead of the current state, with the full carry chain.
    always_comb begin
        sec_n    = sec_q + MS_W'(1);
        min_n    = min_q;
        hour24_n = hour24_q;
        if (sec_q == SEC_MAX) begin
            sec_n = '0;
            if (min_q == MIN_MAX) begin
                min_n    = '0;
                hour24_n = (hour24_q == HOUR24_MAX) ? '0 : (hour24_q + HOUR_W'(1));
            end else begin
                min_n = min_q + MS_W'(1);
            end
        end
    end

    // Out-of-range alarm fields can never equal a legal next time.
    assign alarm_match = alarm_en
                      && (hour24_n == alarm_hour24)
                      && (min_n    == alarm_min)
                      && (sec_n    == '0);

    // A valid load overrides a coincident advance; a rejected load leaves
    // the running time alone and only reports the error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hour24_q    <= HOUR_W'(RST_HOUR24);
            min_q       <= '0;
            sec_q       <= '0;
            tick_q      <= 1'b0;
            load_err_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
        end else begin
            tick_q      <= 1'b0;
            load_err_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
            if (load_ok) begin
                hour24_q <= load_hour24;
                min_q    <= load_min;
                sec_q    <= load_sec;
            end else begin
                if (load) begin
                    load_err_q <= 1'b1;
                end
                if (adv) begin
                    hour24_q    <= hour24_n;
                    min_q       <= min_n;
                    sec_q       <= sec_n;
                    tick_q      <= 1'b1;
                    alarm_hit_q <= alarm_match;
                end
            end
        end
    end

    assign disp12    = to_12h(hour24_q);
    assign hours     = mode_24h ? hour24_q : disp12[HOUR_W-1:0];
    assign am_pm     = disp12[HOUR_W];
    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign tick      = tick_q;
    assign load_err  = load_err_q;
    assign alarm_hit = alarm_hit_q;

endmodule

// File: tb/tb_rtc_clock_hms.sv
// Bench for rtc_clock_hms: directed scenarios plus random stimulus, checked
// against a seconds-of-day reference model through an expected queue.
module tb_rtc_clock_hms;

    localparam int TICK_DIV   = 4;
    localparam int RST_HOUR24 = 0;
    localparam int DAY_SECS   = 86400;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       mode_24h;
    logic       load;
    logic [4:0] load_hour24;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic       alarm_en;
    logic [4:0] alarm_hour24;
    logic [5:0] alarm_min;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       am_pm;
    logic       tick;
    logic       load_err;
    logic       alarm_hit;

    rtc_clock_hms #(
        .TICK_DIV   (TICK_DIV),
        .RST_HOUR24 (RST_HOUR24)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .mode_24h     (mode_24h),
        .load         (load),
        .load_hour24  (load_hour24),
        .load_min     (load_min),
        .load_sec     (load_sec),
        .alarm_en     (alarm_en),
        .alarm_hour24 (alarm_hour24),
        .alarm_min    (alarm_min),
        .hours        (hours),
        .minutes      (minutes),
        .seconds      (seconds),
        .am_pm        (am_pm),
        .tick         (tick),
        .load_err     (load_err),
        .alarm_hit    (alarm_hit)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    // Entry layout: {tod[16:0], tick, load_err, alarm_hit}
    logic [19:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int ticks_seen = 0;
    int alarms_seen = 0;
    bit model_started = 1'b0;

    // Reference model: time of day as a plain seconds count plus the number
    // of running cycles since the last second boundary.
    int m_tod   = 0;
    int m_phase = 0;

    always @(posedge clk) begin
        bit e_tick, e_err, e_alarm, adv, ok;
        e_tick  = 1'b0;
        e_err   = 1'b0;
        e_alarm = 1'b0;
        if (!rst_n) begin
            m_tod   = RST_HOUR24 * 3600;
            m_phase = 0;
        end else begin
            adv = run && (m_phase == TICK_DIV - 1);
            if (run) m_phase = (m_phase + 1) % TICK_DIV;
            ok = load && (load_hour24 < 24) && (load_min < 60) && (load_sec < 60);
            if (load && !ok) e_err = 1'b1;
            if (ok) begin
                m_tod   = int'(load_hour24) * 3600 + int'(load_min) * 60 + int'(load_sec);
                m_phase = 0;
            end else if (adv) begin
                m_tod  = (m_tod + 1) % DAY_SECS;
                e_tick = 1'b1;
                if (alarm_en && alarm_hour24 < 24 && alarm_min < 60 &&
                    m_tod == int'(alarm_hour24) * 3600 + int'(alarm_min) * 60)
                    e_alarm = 1'b1;
            end
        end
        exp_q.push_back({17'(m_tod), e_tick, e_err, e_alarm});
        model_started = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a time; compare at the falling edge.
    always @(negedge clk) begin
        logic [19:0] e;
        int tod, h24, exp_hours;
        if (model_started) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL queue_underflow @%0t: got 0 entries expected 1", $time);
            end else begin
                e   = exp_q.pop_front();
                tod = int'(e[19:3]);
                h24 = tod / 3600;
                exp_hours = mode_24h ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
                check("hours",     32'(hours),   32'(exp_hours));
                check("minutes",   32'(minutes), 32'((tod / 60) % 60));
                check("seconds",   32'(seconds), 32'(tod % 60));
                check("am_pm",     32'(am_pm),   32'(h24 >= 12));
                check("tick",      32'(tick),      32'(e[2]));
                check("load_err",  32'(load_err),  32'(e[1]));
                check("alarm_hit", 32'(alarm_hit), 32'(e[0]));
                if (tick === 1'b1) ticks_seen++;
                if (alarm_hit === 1'b1) alarms_seen++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load        = 1'b1;
        load_hour24 = 5'(h);
        load_min    = 6'(m);
        load_sec    = 6'(s);
        step(1);
        load = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lh, lm, ls;
        rst_n = 1'b0; run = 1'b0; mode_24h = 1'b0; load = 1'b0;
        load_hour24 = '0; load_min = '0; load_sec = '0;
        alarm_en = 1'b0; alarm_hour24 = '0; alarm_min = '0;

        // Reset held for three cycles, then free running, freeze and resume.
        step(3);
        rst_n = 1'b1;
        run   = 1'b1;
        step(13);
        run = 1'b0;
        step(10);
        run = 1'b1;
        step(9);

        // Rollovers in both display modes.
        do_load(11, 59, 59);
        step(5);
        do_load(23, 59, 59);
        step(5);
        mode_24h = 1'b1;
        do_load(23, 59, 59);
        step(5);
        run = 1'b0;
        do_load(13, 0, 0);
        mode_24h = 1'b0;
        step(2);
        mode_24h = 1'b1;
        step(2);
        mode_24h = 1'b0;
        run = 1'b1;

        // Rejected load, then a load landing on an advance edge.
        do_load(24, 0, 0);
        step(3);
        do_load(10, 61, 0);
        step(2);
        do_load(8, 0, 0);
        step(3);
        do_load(9, 15, 30);
        step(9);

        // Alarm at 07:30; a direct load onto it must stay silent.
        alarm_hour24 = 5'd7;
        alarm_min    = 6'd30;
        alarm_en     = 1'b1;
        do_load(7, 29, 58);
        step(13);
        do_load(7, 30, 0);
        step(6);
        alarm_en = 1'b0;
        do_load(7, 29, 59);
        step(6);
        // Out-of-range minute must not alias onto 08:00:00.
        alarm_en     = 1'b1;
        alarm_min    = 6'd60;
        do_load(7, 59, 59);
        step(6);

        // Reset part-way through a second.
        do_load(5, 10, 20);
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(9);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            run   = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) mode_24h = ~mode_24h;
            load_hour24 = 5'($urandom_range(0, 31));
            load_min    = 6'($urandom_range(0, 63));
            load_sec    = 6'($urandom_range(0, 63));
            load        = ($urandom_range(0, 39) == 0);
            if (load && $urandom_range(0, 3) != 0) begin
                lh = $urandom_range(0, 23);
                lm = $urandom_range(0, 59);
                ls = $urandom_range(50, 59);
                load_hour24 = 5'(lh);
                load_min    = 6'(lm);
                load_sec    = 6'(ls);
                alarm_en    = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) begin
                    alarm_hour24 = 5'(lh);
                    alarm_min    = 6'd60;
                end else if (lm == 59) begin
                    alarm_hour24 = 5'((lh + 1) % 24);
                    alarm_min    = 6'd0;
                end else begin
                    alarm_hour24 = 5'(lh);
                    alarm_min    = 6'(lm + 1);
                end
            end
            step(1);
        end
        load  = 1'b0;
        rst_n = 1'b1;
        step(4);

        @(negedge clk);
        #1;
        checks++;
        if (ticks_seen == 0 || alarms_seen == 0) begin
            failures++;
            $display("FAIL activity: got ticks=%0d alarms=%0d expected both nonzero",
                     ticks_seen, alarms_seen);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_clock_hms.md
Name: rtc_clock_hms

Overview:
Parametrised real-time hours/minutes/seconds counter. It generalises the 12-hour clock block with:
- an internal prescaler, so the block runs from the fabric clock and needs no external 1 Hz clock;
- run-time selection of 12h or 24h display;
- synchronous time-load with range checking;
- a one-shot alarm comparator.

It sits between the system clock domain and the display/alarm logic.

Parameters:
TICK_DIV, 50_000_000, clk cycles per one-second tick (>=2); prescaler width = clog2(TICK_DIV).
RST_HOUR24, 0, hour24 value loaded on reset (0 = 12:00:00 AM).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
run  in  1  1 = prescaler counts; 0 = time frozen, prescaler held.
mode_24h  in  1  0 = 12h display (hours 1..12 + am_pm); 1 = 24h display (hours 0..23).
load  in  1  one-cycle strobe: load time fields below.
load_hour24  in  5  hour to load, 0..23.
load_min  in  6  minute to load, 0..59.
load_sec  in  6  second to load, 0..59.
alarm_en  in  1  alarm comparator enable.
alarm_hour24  in  5  alarm hour, 0..23.
alarm_min  in  6  alarm minute, 0..59.
hours  out  5  displayed hour, per mode_24h.
minutes  out  6  current minute.
seconds  out  6  current second.
am_pm  out  1  0 = AM (hour24 0..11), 1 = PM (12..23); valid in both modes.
tick  out  1  one-cycle pulse on each second advance.
load_err  out  1  one-cycle pulse: load rejected (field out of range).
alarm_hit  out  1  one-cycle pulse on alarm match.

Behaviour:
- State registers: prescaler cnt, hour24 (0..23), min, sec.
- Display decode is combinational from state and mode_24h:
  - hours = hour24 if mode_24h; else (hour24 mod 12 == 0 ? 12 : hour24 mod 12).
  - am_pm = (hour24 >= 12).
- Reset (rst_n=0 at a clk edge) clears everything:
  - cnt=0, hour24=RST_HOUR24, min=0, sec=0.
  - tick=0, load_err=0, alarm_hit=0.
  - Default display: 12:00:00, am_pm=0 in 12h mode.
  - Reset mid-count discards the partial prescaler count.
- Prescaler, when run=1:
  - cnt increments each cycle.
  - When cnt==TICK_DIV-1: cnt<=0 and a second advance occurs at that edge.
  - tick is registered and asserts in the cycle after that edge, i.e. coincident with the new time on the outputs.
  - Period is exactly TICK_DIV cycles.
- run=0: cnt holds, no advance.
- Second advance (carry chain), all in one edge:
  - sec 59->0 carries into min.
  - min 59->0 carries into hour24.
  - hour24 23->0 wraps. 23:59:59 -> 00:00:00, displayed 11:59:59 PM -> 12:00:00 AM.
  - 11:59:59 -> 12:00:00 toggles am_pm 0->1.
- Load, sampled when load=1:
  - If any field is out of range: no state change, load_err pulses next cycle.
  - Otherwise hour24/min/sec take the load values and cnt<=0. The next tick follows a full TICK_DIV cycles after the load.
  - Load wins over a coincident second advance: that advance is dropped and no tick is issued.
  - Load works while run=0.
  - A load does not generate alarm_hit, even if it lands on the alarm time.
- Alarm:
  - Fires only on a second advance whose new time equals alarm_hour24:alarm_min:00, with alarm_en=1.
  - alarm_hit pulses in the same cycle as the corresponding tick.
  - Fires once per 24 h match.
  - alarm_en is sampled at the advance edge.
  - Out-of-range alarm fields never match.
- Outputs hours/minutes/seconds/am_pm change only at advance/load/reset edges.

Decomposition:
- Package rtc_pkg holds:
  - constants SEC_MAX=59, MIN_MAX=59, HOUR24_MAX=23;
  - field widths HOUR_W=5, MS_W=6;
  - function to_12h(hour24) returning {am_pm, hour12}.
- One sub-module, rtc_prescaler: parametrised by TICK_DIV; inputs run and clr; output adv; synchronous active-low reset.
- The carry chain, load check and alarm compare stay in the top module.

Test Plan:
- Reset: TICK_DIV=4, hold rst_n=0 for 3 cycles, mode_24h=0 -> hours=12, minutes=0, seconds=0, am_pm=0, no tick.
- Tick period: run=1 -> tick every 4 cycles exactly; seconds 0->1->2. With run=0 for 10 cycles -> no ticks, seconds held, and the period resumes from the held count.
- Rollover and mode: load 11:59:59, advance -> 12:00:00, am_pm=1. Load 23:59:59, advance -> 12:00:00 AM in 12h mode and 0:00:00 in 24h mode. Toggle mode_24h at hour24=13 -> hours reads 1 then 13.
- Load checks: load_hour24=24 -> load_err pulse, time unchanged. Assert load on the same cycle as an advance edge -> loaded value shown, no tick, next tick 4 cycles later.
- Alarm: alarm 07:30, load 07:29:58, alarm_en=1 -> alarm_hit only with the 07:30:00 tick. Load 07:30:00 directly -> no alarm_hit. alarm_en=0 -> no hit.
- Reset mid-operation: deassert rst_n when cnt=2 at 05:10:20 -> next cycle 12:00:00 AM, cnt=0, no pending tick or alarm_hit.
